match_clear: RTL and testbench

Match detector and eliminator for the 8x8 board. It sits directly upstream of the column-compaction (`refresh`) stage. On `start` it latches the current board and scans every row and every column for runs of three or more equal non-empty cells. It then zeroes every matched cell and presents the cleared board, the match mask and the match count to the compaction stage.

---
 rtl/game_pkg.sv | 32 +++
 rtl/match_clear_if.sv | 33 +++
 rtl/run_detect8.sv | 36 +++
 rtl/match_clear.sv | 145 ++++++++++++++
 tb/tb_match_clear.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared board geometry, cell helpers and the match FSM state type.
package game_pkg;
  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int CELL_BITS = 3;
  localparam logic [CELL_BITS-1:0] EMPTY = 3'd0;

  localparam int NCELLS  = ROWS * COLS;
  localparam int BOARD_W = NCELLS * CELL_BITS;
  localparam int CNT_W   = 7;
  localparam int SCORE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_H,
    SCAN_V,
    APPLY,
    DONE
  } match_state_t;

  // Flat cell index of (r,c); the cell's bits start at cell_idx(r,c)*CELL_BITS.
  function automatic int cell_idx(input int r, input int c);
    return r * COLS + c;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NCELLS-1:0] m);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NCELLS; i++) n = n + CNT_W'(m[i]);
    return n;
  endfunction
endpackage

// File: rtl/match_clear_if.sv
// Request/result bundle between the board owner and match_clear.
// The score field exists only when MATCH_SCORE_EN is defined.
interface match_clear_if;
  import game_pkg::*;

  logic                 start;
  logic [BOARD_W-1:0]   board;
  logic [BOARD_W-1:0]   cleared_board;
  logic [NCELLS-1:0]    match_mask;
  logic [CNT_W-1:0]     match_count;
  logic                 found;
  logic                 busy;
  logic                 done;
`ifdef MATCH_SCORE_EN
  logic [SCORE_W-1:0]   score;
`endif

  modport master (
    output start, board,
    input  cleared_board, match_mask, match_count, found, busy, done
`ifdef MATCH_SCORE_EN
    , score
`endif
  );

  modport slave (
    input  start, board,
    output cleared_board, match_mask, match_count, found, busy, done
`ifdef MATCH_SCORE_EN
    , score
`endif
  );
endinterface

// File: rtl/run_detect8.sv
// Combinational run finder for one 8-cell line: marks cells in runs of >=3
// equal non-empty colours and counts runs of length >=4.
module run_detect8
  import game_pkg::*;
#(
  parameter int CELL_BITS = game_pkg::CELL_BITS
) (
  input  logic [8*CELL_BITS-1:0] cells,
  output logic [7:0]             mask,
  output logic [1:0]             runs4
);
  logic [CELL_BITS-1:0] c [8];
  logic [5:0]           w3;

  always_comb begin
    for (int i = 0; i < 8; i++) c[i] = cells[i*CELL_BITS +: CELL_BITS];
  end

  // w3[j]: cells j..j+2 share a non-empty colour; any L>=3 run is a union of these.
  always_comb begin
    w3   = '0;
    mask = '0;
    for (int j = 0; j < 6; j++) begin
      w3[j] = (c[j] != EMPTY) && (c[j] == c[j+1]) && (c[j+1] == c[j+2]);
      if (w3[j]) mask = mask | (8'b0000_0111 << j);
    end
  end

  // A run of >=4 is counted once, at its leftmost window.
  always_comb begin
    runs4 = '0;
    if (w3[0] && w3[1]) runs4 = runs4 + 2'd1;
    for (int j = 1; j < 5; j++)
      if (w3[j] && w3[j+1] && (c[j-1] != c[j])) runs4 = runs4 + 2'd1;
  end
endmodule

// File: rtl/match_clear.sv
// Match detector/eliminator: scans 8 rows then 8 columns through one shared
// run_detect8, then zeroes matched cells. MATCH_SCORE_EN adds the score counter.
module match_clear #(
  parameter int ROWS      = game_pkg::ROWS,
  parameter int COLS      = game_pkg::COLS,
  parameter int CELL_BITS = game_pkg::CELL_BITS
) (
  input  logic         clk,
  input  logic         reset,
  match_clear_if.slave mc
);
  import game_pkg::*;

  localparam int NC = ROWS * COLS;
  localparam int BW = NC * CELL_BITS;

  match_state_t          state, nstate;
  logic [2:0]            cnt;
  logic [BW-1:0]         latched;
  logic [NC-1:0]         mask_acc;

  logic [8*CELL_BITS-1:0] line;
  logic [7:0]            lmask;
  logic [1:0]            lruns4;

  logic [BW-1:0]         clr_next;
  logic [CNT_W-1:0]      cnt_next;

  logic [BW-1:0]         cb_q;
  logic [NC-1:0]         mask_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  found_q;
  logic                  done_q;

  // Row k in SCAN_H, column k in SCAN_V, both from the latched copy.
  always_comb begin
    line = '0;
    for (int i = 0; i < 8; i++) begin
      if (state == SCAN_V)
        line[i*CELL_BITS +: CELL_BITS] = latched[{3'(i), cnt}*CELL_BITS +: CELL_BITS];
      else
        line[i*CELL_BITS +: CELL_BITS] = latched[{cnt, 3'(i)}*CELL_BITS +: CELL_BITS];
    end
  end

  run_detect8 #(.CELL_BITS(CELL_BITS)) u_det (
    .cells (line),
    .mask  (lmask),
    .runs4 (lruns4)
  );

  for (genvar g = 0; g < NC; g++) begin : g_clr
    assign clr_next[g*CELL_BITS +: CELL_BITS] =
      mask_acc[g] ? EMPTY : latched[g*CELL_BITS +: CELL_BITS];
  end

  assign cnt_next = popcount(mask_acc);

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (mc.start) nstate = SCAN_H;
      SCAN_H:  if (cnt == 3'd7) nstate = SCAN_V;
      SCAN_V:  if (cnt == 3'd7) nstate = APPLY;
      APPLY:   nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      latched  <= '0;
      mask_acc <= '0;
      cb_q     <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= nstate;
      done_q <= (state == DONE);
      case (state)
        IDLE: if (mc.start) begin
          latched  <= mc.board;
          mask_acc <= '0;
          cnt      <= '0;
        end
        SCAN_H: begin
          mask_acc[{cnt, 3'b000} +: 8] <= mask_acc[{cnt, 3'b000} +: 8] | lmask;
          cnt <= cnt + 3'd1;
        end
        SCAN_V: begin
          for (int i = 0; i < 8; i++)
            if (lmask[i]) mask_acc[{3'(i), cnt}] <= 1'b1;
          cnt <= cnt + 3'd1;
        end
        APPLY: begin
          cb_q    <= clr_next;
          mask_q  <= mask_acc;
          cnt_q   <= cnt_next;
          found_q <= (cnt_next != '0);
        end
        default: ;
      endcase
    end
  end

`ifdef MATCH_SCORE_EN
  logic [SCORE_W-1:0] score_q;
  logic [5:0]         bonus_acc;
  logic [SCORE_W:0]   score_sum;

  // Each run of >=4 is worth 2 on top of the per-cell count.
  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(cnt_next) + (SCORE_W+1)'({bonus_acc, 1'b0});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q   <= '0;
      bonus_acc <= '0;
    end else begin
      case (state)
        IDLE:           if (mc.start) bonus_acc <= '0;
        SCAN_H, SCAN_V: bonus_acc <= bonus_acc + 6'(lruns4);
        APPLY:          score_q <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        default: ;
      endcase
    end
  end

  assign mc.score = score_q;
`else
  logic unused_runs4;
  assign unused_runs4 = ^lruns4;
`endif

  assign mc.cleared_board = cb_q;
  assign mc.match_mask    = mask_q;
  assign mc.match_count   = cnt_q;
  assign mc.found         = found_q;
  assign mc.done          = done_q;
  assign mc.busy          = (state != IDLE);
endmodule

// File: tb/tb_match_clear.sv
// Scoreboard bench for match_clear: directed boards push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_match_clear;
  import game_pkg::*;

  logic clk;
  logic reset;
  match_clear_if mc ();

  match_clear dut (.clk(clk), .reset(reset), .mc(mc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BOARD_W-1:0] clr;
    logic [NCELLS-1:0]  mask;
    logic [CNT_W-1:0]   cnt;
    logic               found;
    logic [15:0]        score;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_score = '0;

  task automatic chk(input string nm, input logic [BOARD_W-1:0] act, input logic [BOARD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [BOARD_W-1:0] checker2(input logic [2:0] a, input logic [2:0] b);
    logic [BOARD_W-1:0] bd;
    bd = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        bd[cell_idx(r, c)*3 +: 3] = ((r + c) % 2 != 0) ? b : a;
    return bd;
  endfunction

  function automatic logic [BOARD_W-1:0] set_cell(input logic [BOARD_W-1:0] bd, input int r, input int c,
                                                  input logic [2:0] v);
    logic [BOARD_W-1:0] o;
    o = bd;
    o[cell_idx(r, c)*3 +: 3] = v;
    return o;
  endfunction

  // Monitor: every done must correspond to a queued expectation.
  always @(negedge clk) begin
    if (!reset && mc.done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", BOARD_W'(cyc), BOARD_W'(e.cyc));
        chk("match_mask", BOARD_W'(mc.match_mask), BOARD_W'(e.mask));
        chk("match_count", BOARD_W'(mc.match_count), BOARD_W'(e.cnt));
        chk("found", BOARD_W'(mc.found), BOARD_W'(e.found));
        chk("cleared_board", mc.cleared_board, e.clr);
`ifdef MATCH_SCORE_EN
        chk("score", BOARD_W'(mc.score), BOARD_W'(e.score));
`endif
      end
    end
  end

  task automatic run_scan(input logic [BOARD_W-1:0] b, input logic [BOARD_W-1:0] clr,
                          input logic [NCELLS-1:0] mask, input int cnt, input int bonus,
                          input bit disturb);
    exp_t e;
    int   s;
    @(negedge clk);
    mc.board = b;
    mc.start = 1'b1;
    s = int'(exp_score) + cnt + bonus;
    exp_score = (s > 16'hFFFF) ? 16'hFFFF : 16'(s);
    e.clr = clr; e.mask = mask; e.cnt = CNT_W'(cnt); e.found = (cnt != 0);
    e.score = exp_score; e.cyc = cyc + 19;
    q.push_back(e);
    @(negedge clk);
    mc.start = 1'b0;
    chk("busy_after_start", BOARD_W'(mc.busy), BOARD_W'(1));
    if (disturb) begin
      mc.board = {(BOARD_W/3){3'd5}};
      repeat (10) @(negedge clk);
      mc.start = 1'b1;
      @(negedge clk);
      mc.start = 1'b0;
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done at cycle %0d", e.cyc);
      q.delete();
    end
    @(negedge clk);
    chk("busy_idle", BOARD_W'(mc.busy), BOARD_W'(0));
    repeat (disturb ? 25 : 2) @(negedge clk);
    chk("count_held", BOARD_W'(mc.match_count), BOARD_W'(cnt));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_cleared"}, mc.cleared_board, '0);
    chk({nm, "_mask"}, BOARD_W'(mc.match_mask), '0);
    chk({nm, "_count"}, BOARD_W'(mc.match_count), '0);
    chk({nm, "_found"}, BOARD_W'(mc.found), '0);
    chk({nm, "_busy"}, BOARD_W'(mc.busy), '0);
    chk({nm, "_done"}, BOARD_W'(mc.done), '0);
`ifdef MATCH_SCORE_EN
    chk({nm, "_score"}, BOARD_W'(mc.score), '0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BOARD_W-1:0] b2, c2, bt, ct, b7, c7;
    logic [NCELLS-1:0]  mt;

    reset = 1'b1;
    mc.start = 1'b0;
    mc.board = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // Empty board: nothing matches.
    run_scan('0, '0, '0, 0, 0, 1'b0);

    // Row 2 cols 0-2 colour 5 on a 1/2 checkerboard.
    b2 = checker2(3'd1, 3'd2);
    c2 = b2;
    for (int c = 0; c < 3; c++) begin
      b2 = set_cell(b2, 2, c, 3'd5);
      c2 = set_cell(c2, 2, c, 3'd0);
    end
    run_scan(b2, c2, 64'h0000_0000_0007_0000, 3, 0, 1'b0);

    // T-shape of colour 2 on a 6/7 checkerboard; column run of 5 earns a bonus.
    bt = checker2(3'd6, 3'd7);
    ct = bt;
    for (int c = 3; c <= 5; c++) begin
      bt = set_cell(bt, 4, c, 3'd2);
      ct = set_cell(ct, 4, c, 3'd0);
    end
    for (int r = 2; r <= 6; r++) begin
      bt = set_cell(bt, r, 4, 3'd2);
      ct = set_cell(ct, r, 4, 3'd0);
    end
    mt = 64'h0010_1038_1010_0000;
    run_scan(bt, ct, mt, 7, 2, 1'b0);

    // Reset ten cycles into a scan: no done, everything back to zero.
    @(negedge clk);
    mc.board = bt;
    mc.start = 1'b1;
    @(negedge clk);
    mc.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    exp_score = '0;
    repeat (2) @(negedge clk);
    chk_zero("midscan_reset");
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk_zero("after_reset");

    // Full row 7 of colour 1 (run of 8), twice with the same board.
    b7 = checker2(3'd6, 3'd7);
    c7 = b7;
    for (int c = 0; c < 8; c++) begin
      b7 = set_cell(b7, 7, c, 3'd1);
      c7 = set_cell(c7, 7, c, 3'd0);
    end
    run_scan(b7, c7, 64'hFF00_0000_0000_0000, 8, 2, 1'b0);
    run_scan(b7, c7, 64'hFF00_0000_0000_0000, 8, 2, 1'b0);

    // Board changed after latch and start pulsed during SCAN_V.
    run_scan(b2, c2, 64'h0000_0000_0007_0000, 3, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
